// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the 8-bit CPU. It reads the current PC, issues
// byte reads to program memory over a req/ack handshake, and assembles 1- or
// 2-byte instructions. The opcode's MSB selects the length: 0 means 1 byte,
// 1 means opcode plus operand. Each assembled instruction is presented to
// decode over a valid/ready handshake. A taken branch from execute redirects
// the PC and restarts fetch at the branch target.
//
// Ports:
//   clk, reset          system clock (rising edge), async active-high reset
//   pc                  current PC from program_counter
//   pc_increment        one-cycle pulse to advance the PC
//   pc_load/pc_new_addr PC redirect on a taken branch
//   mem_addr/mem_req    program memory read address (= pc) and request
//   mem_ack/mem_rdata   memory read data valid / data
//   instr_valid/ready   handshake to decode
//   opcode/operand      assembled instruction (operand 0 for 1-byte)
//   branch_taken/target redirect request from execute
//   halted              fetch stopped on HLT
//
// Configuration macro: FETCH_HALT_EN
//   defined   - opcode 0xFF is HLT; once decode accepts it, fetch parks in
//               HALTED until reset or a taken branch.
//   undefined - 0xFF is an ordinary 2-byte instruction; halted is tied to 0.
// ---------------------------------------------------------------------------
module fetch_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pc,
    output logic       pc_increment,
    output logic       pc_load,
    output logic [7:0] pc_new_addr,
    output logic [7:0] mem_addr,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic       halted
);

    typedef enum logic [2:0] {
        START   = 3'd0,
        REQ_OP  = 3'd1,
        REQ_ARG = 3'd2,
        HOLD    = 3'd3,
        HALTED  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] operand_q, operand_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= START;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    // Next-state and PC control. A branch outranks everything except START,
    // so a coincident ack is dropped without latching or advancing the PC.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        operand_d    = operand_q;
        pc_increment = 1'b0;
        pc_load      = 1'b0;
        pc_new_addr  = 8'h00;

        if (state_q == START) begin
            state_d = REQ_OP;
        end else if (branch_taken) begin
            pc_load     = 1'b1;
            pc_new_addr = branch_target;
            state_d     = REQ_OP;
        end else begin
            case (state_q)
                REQ_OP: begin
                    if (mem_ack) begin
                        opcode_d     = mem_rdata;
                        operand_d    = 8'h00;
                        pc_increment = 1'b1;
                        state_d      = mem_rdata[7] ? REQ_ARG : HOLD;
                    end
                end
                REQ_ARG: begin
                    if (mem_ack) begin
                        operand_d    = mem_rdata;
                        pc_increment = 1'b1;
                        state_d      = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
`ifdef FETCH_HALT_EN
                        state_d = (opcode_q == 8'hFF) ? HALTED : REQ_OP;
`else
                        state_d = REQ_OP;
`endif
                    end
                end
                HALTED: begin
                    // Only reset or a branch (handled above) leaves here.
                    state_d = HALTED;
                end
                default: begin
                    state_d = START;
                end
            endcase
        end
    end

    assign mem_addr    = pc;
    assign mem_req     = (state_q == REQ_OP) || (state_q == REQ_ARG);
    assign instr_valid = (state_q == HOLD);
    assign opcode      = opcode_q;
    assign operand     = operand_q;

`ifdef FETCH_HALT_EN
    assign halted = (state_q == HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 8-bit CPU, directly downstream of `program_counter`. It reads `pc`, issues byte reads to program memory over a req/ack handshake, and assembles 1- or 2-byte instructions. It presents each assembled instruction to decode over a valid/ready handshake. It drives the PC's `increment` and `load`/`new_addr` inputs, including redirects on taken branches.

## Interface
- No parameters; datapath fixed at 8 bits.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `pc` input 8: current PC value from `program_counter`.
- `pc_increment` output 1: one-cycle pulse to PC `increment`.
- `pc_load` output 1: to PC `load`.
- `pc_new_addr` output 8: to PC `new_addr`.
- `mem_addr` output 8: read address; always equals `pc`.
- `mem_req` output 1: read request; held until acknowledged.
- `mem_ack` input 1: read data valid this cycle.
- `mem_rdata` input 8: read data, sampled when `mem_ack`=1.
- `instr_valid` output 1: assembled instruction available.
- `instr_ready` input 1: decode accepts instruction.
- `opcode` output 8: instruction opcode byte.
- `operand` output 8: second byte; 0 for 1-byte instructions.
- `branch_taken` input 1: redirect request from execute.
- `branch_target` input 8: redirect address.
- `halted` output 1: fetch stopped on HLT.

## Operation
- Instruction length rule: `opcode[7]`=0 means 1 byte; `opcode[7]`=1 means 2 bytes (opcode, operand).
- States: START, REQ_OP, REQ_ARG, HOLD, HALTED.
  - START (reset state) -> REQ_OP unconditionally at the first edge after reset deasserts.
  - REQ_OP: `mem_req`=1. On `mem_ack`: latch `opcode`, clear `operand`, pulse `pc_increment`. Next state is REQ_ARG if `mem_rdata[7]`=1, else HOLD.
  - REQ_ARG: `mem_req`=1. On `mem_ack`: latch `operand`, pulse `pc_increment`, go to HOLD.
  - HOLD: `instr_valid`=1. `opcode` and `operand` stay stable. On `instr_ready`, go to REQ_OP (or HALTED, see Configuration).
  - HALTED: `halted`=1, `mem_req`=0, `instr_valid`=0.
- `mem_req`, `instr_valid`, and `halted` are Moore outputs decoded from state.
- `pc_increment`, `pc_load`, and `pc_new_addr` are combinational.
- Branch: `branch_taken`=1 in any state except START has top priority.
  - Drives `pc_load`=1 and `pc_new_addr`=`branch_target` the same cycle; next state is REQ_OP.
  - A coincident `mem_ack` is discarded: no latch, no `pc_increment`.
  - A held instruction is dropped. If `instr_ready`=1 in the same cycle, the transfer still counts as accepted.
- `pc_load` and `pc_increment` are never asserted together.
- `pc_new_addr` is 0 when `pc_load`=0.
- `mem_req` never drops without `mem_ack`, except on branch or reset.
- Reset mid-fetch: all state is lost and the outstanding request is abandoned. Memory must tolerate an unacknowledged abandon.

## Timing
- Reset values: state=START. `mem_req`, `instr_valid`, `halted`, `pc_increment`, `pc_load` = 0. `opcode`, `operand`, `pc_new_addr` = 0.
- `mem_ack` must only be asserted while `mem_req`=1. Zero-wait-state acks (same cycle as the request) are legal.
- Best-case throughput:
  - 1-byte instruction: 1 cycle in REQ_OP, 1 cycle in HOLD.
  - 2-byte instruction: 3 cycles.
- After an ack, `pc` updates at the edge, so the next request's `mem_addr` shows the incremented PC.
- Branch-to-first-request latency: 1 cycle. `mem_addr`=`branch_target` in the cycle after `branch_taken`.
- `pc` wraps 0xFF -> 0x00 inside `program_counter`; no special handling here. A 2-byte instruction at 0xFF takes its operand from 0x00.

## Configuration
- `FETCH_HALT_EN` defined:
  - Opcode 0xFF is HLT.
  - It is delivered normally as a 2-byte instruction.
  - On its acceptance, HOLD -> HALTED instead of REQ_OP.
  - HALTED exits only via `reset` or `branch_taken`.
- `FETCH_HALT_EN` undefined:
  - 0xFF is an ordinary 2-byte instruction.
  - HALTED is unreachable.
  - `halted` is tied to 0.

## Test plan
- Reset, then zero-wait memory with 0x10 at 0x00 and `instr_ready`=1:
  - `mem_req` rises 1 cycle after reset deasserts.
  - `opcode`=0x10 and `operand`=0x00 valid in HOLD.
  - Exactly one `pc_increment` pulse.
- Memory holds 0x85, 0x3C at 0x04/0x05 with 2-cycle ack latency:
  - `mem_req` stays high through each wait.
  - `instr_valid` with `opcode`=0x85, `operand`=0x3C.
  - Two `pc_increment` pulses in total.
- `instr_ready`=0 for 5 cycles in HOLD:
  - `instr_valid` and the held bytes stay stable.
  - `mem_req`=0 throughout; no PC change.
- `branch_taken`=1, `branch_target`=0x40 in the same cycle as `mem_ack` in REQ_ARG:
  - `pc_load`=1, `pc_new_addr`=0x40, no `pc_increment`.
  - Next cycle: `mem_addr`=0x40 and `mem_req`=1.
- `FETCH_HALT_EN` on, 0xFF 0x00 at 0x10, accepted:
  - `halted`=1 and `mem_req`=0 for 10 cycles.
  - `branch_taken` to 0x00 resumes fetch at 0x00.
  - With the macro off, the fetch continues at 0x12.
- Assert `reset` while in REQ_ARG:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - Restart follows from START.
